// File: rtl/thumb_pkg.sv
// rtl/thumb_pkg.sv - shared constants for the Thumb fetch/decode datapath
package thumb_pkg;
  localparam int          ADDR_W_DEF   = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam int          HW_INC       = 2;

  // Register indices the decoder maps special operands onto
  localparam logic [3:0] REG_SP = 4'hD;
  localparam logic [3:0] REG_LR = 4'hE;
  localparam logic [3:0] REG_PC = 4'hF;
endpackage

// File: rtl/thumb_fetch_fifo.sv
// rtl/thumb_fetch_fifo.sv - DEPTH-entry prefetch FIFO of {pc, instr} with flush
module thumb_fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so pointers wrap on their own
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/thumb_fetch.sv
// rtl/thumb_fetch.sv - Thumb fetch unit: PC, imem issue, prefetch FIFO, redirect flush
// Optional perf counters (fetch_cnt, bubble_cnt) under THUMB_FETCH_PERF_EN.
module thumb_fetch
  import thumb_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef THUMB_FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       bubble_cnt
`endif
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + 16;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              kill;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic [CNT_W:0]    occupancy;
  logic              pop;
  logic              push;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign push        = inflight && !kill && !redirect;

  // Slots already promised: buffered plus in-flight, less what leaves this cycle
  assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign imem_req  = !reset && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
  assign imem_addr = imem_req ? fetch_pc : '0;

  assign instr    = instr_valid ? head[15:0] : '0;
  assign instr_pc = instr_valid ? head[ENT_W-1:16] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= {RESET_PC[ADDR_W-1:1], 1'b0};
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else begin
      inflight <= imem_req;
      kill     <= 1'b0;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(HW_INC);
      end
      // Redirect issues nothing; kill guards any response landing after the flush
      if (redirect) begin
        fetch_pc <= {redirect_pc[ADDR_W-1:1], 1'b0};
        kill     <= 1'b1;
      end
    end
  end

  thumb_fetch_fifo #(
    .DEPTH(DEPTH),
    .W    (ENT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data({inflight_pc, imem_rdata}),
    .pop      (pop),
    .flush    (redirect),
    .count    (count),
    .head     (head)
  );

`ifdef THUMB_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (pop && fetch_cnt != 16'hFFFF)           fetch_cnt  <= fetch_cnt + 16'd1;
      if (!instr_valid && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_thumb_fetch.sv
// tb/tb_thumb_fetch.sv - directed self-checking bench for thumb_fetch
module tb_thumb_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
`ifdef THUMB_FETCH_PERF_EN
  logic [15:0] fetch_cnt;
  logic [15:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  thumb_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
`ifdef THUMB_FETCH_PERF_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    case (a)
      16'h0000: mem_fn = 16'h2005;
      16'h0002: mem_fn = 16'h3101;
      default:  mem_fn = a ^ 16'h5A5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_fn(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input logic r, input logic [15:0] a);
    check("imem_req", 32'(imem_req), 32'(r));
    check("imem_addr", 32'(imem_addr), r ? 32'(a) : 32'h0);
  endtask

  task automatic chk_instr(input logic v, input logic [15:0] pc);
    check($sformatf("instr_valid@%h", pc), 32'(instr_valid), 32'(v));
    check($sformatf("instr_pc@%h", pc), 32'(instr_pc), v ? 32'(pc) : 32'h0);
    check($sformatf("instr@%h", pc), 32'(instr), v ? 32'(mem_fn(pc)) : 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    repeat (3) step();
    #1;
    chk_req(1'b0, 16'h0000);
    chk_instr(1'b0, 16'h0000);
`ifdef THUMB_FETCH_PERF_EN
    check("fetch_cnt_rst", 32'(fetch_cnt), 32'h0);
    check("bubble_cnt_rst", 32'(bubble_cnt), 32'h0);
`endif

    // startup
    step(); reset = 1'b0; #1;
    chk_req(1'b1, 16'h0000); chk_instr(1'b0, 16'h0000);
    step(); #1;
    chk_req(1'b1, 16'h0002); chk_instr(1'b0, 16'h0000);
    step(); #1;
    chk_instr(1'b1, 16'h0000);
`ifdef THUMB_FETCH_PERF_EN
    check("bubble_cnt_c2", 32'(bubble_cnt), 32'd2);
    check("fetch_cnt_c2", 32'(fetch_cnt), 32'd0);
`endif
    step(); #1;
    chk_instr(1'b1, 16'h0002);
`ifdef THUMB_FETCH_PERF_EN
    check("fetch_cnt_c3", 32'(fetch_cnt), 32'd1);
`endif

    // backpressure
    step(); instr_ready = 1'b0; #1;
    chk_instr(1'b1, 16'h0004);
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      chk_req(1'b0, 16'h0000);
      chk_instr(1'b1, 16'h0004);
    end
    step(); instr_ready = 1'b1; #1;
    chk_req(1'b1, 16'h0008);
    chk_instr(1'b1, 16'h0004);
    for (int k = 1; k <= 5; k++) begin
      step(); #1;
      chk_instr(1'b1, 16'(16'h0004 + 2 * k));
    end

    // redirect to odd target
    step(); redirect = 1'b1; redirect_pc = 16'h0041; #1;
    chk_req(1'b0, 16'h0000);
    chk_instr(1'b1, 16'h0010);
    step(); redirect = 1'b0; #1;
    chk_req(1'b1, 16'h0040); chk_instr(1'b0, 16'h0000);
    step(); #1;
    chk_req(1'b1, 16'h0042); chk_instr(1'b0, 16'h0000);
    step(); #1;
    chk_instr(1'b1, 16'h0040);
    step(); #1;
    chk_instr(1'b1, 16'h0042);

    // back-to-back redirects
    step(); redirect = 1'b1; redirect_pc = 16'h0100; #1;
    step(); redirect_pc = 16'h0201; #1;
    chk_req(1'b0, 16'h0000);
    step(); redirect = 1'b0; #1;
    chk_req(1'b1, 16'h0200);
    step(); #1;
    step(); #1;
    chk_instr(1'b1, 16'h0200);

    // address wrap
    step(); redirect = 1'b1; redirect_pc = 16'hFFFC; #1;
    step(); redirect = 1'b0; #1;
    chk_req(1'b1, 16'hFFFC);
    step(); #1;
    chk_req(1'b1, 16'hFFFE);
    step(); #1;
    chk_instr(1'b1, 16'hFFFC);
    step(); #1;
    chk_instr(1'b1, 16'hFFFE);
    step(); #1;
    chk_instr(1'b1, 16'h0000);

    // reset mid-stream with a full FIFO; redirect during reset ignored
    step(); instr_ready = 1'b0; #1;
    step(); #1;
    chk_instr(1'b1, 16'h0002);
    chk_req(1'b0, 16'h0000);
    step(); reset = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234; #1;
    chk_req(1'b0, 16'h0000);
    step(); reset = 1'b0; redirect = 1'b0; instr_ready = 1'b1; #1;
    chk_instr(1'b0, 16'h0000);
    chk_req(1'b1, 16'h0000);
    step(); #1;
    chk_instr(1'b0, 16'h0000);
    step(); #1;
    chk_instr(1'b1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
